// File: rtl/fifo_ctrl_if.sv
// rtl/fifo_ctrl_if.sv - producer/consumer and RAM-side signal bundle for fifo_ctrl
interface fifo_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              push;
  logic [DATA_W-1:0] wr_data;
  logic              pop;
  logic              clear_errors;
  logic              mem_write_enable;
  logic [ADDR_W-1:0] mem_write_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_read_enable;
  logic [ADDR_W-1:0] mem_read_address;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, wr_data, pop, clear_errors,
    input  mem_write_enable, mem_write_address, mem_write_data,
    input  mem_read_enable, mem_read_address, rd_valid,
    input  full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  push, wr_data, pop, clear_errors,
    output mem_write_enable, mem_write_address, mem_write_data,
    output mem_read_enable, mem_read_address, rd_valid,
    output full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - pointer, occupancy and flag controller for an 8x8 synchronous FIFO RAM
module fifo_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input logic       clk,
  input logic       rst,
  fifo_ctrl_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_almost_full;
  logic              r_almost_empty;
  logic              r_rd_valid;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_push_ok;
  logic              w_pop_ok;
  logic [ADDR_W:0]   w_count_next;

  // Acceptance depends only on registered flags, so no push/pop path reaches any flag combinationally.
  always_comb begin
    w_push_ok    = bus.push & ~r_full;
    w_pop_ok     = bus.pop & ~r_empty;
    w_count_next = r_count;
    if (w_push_ok && !w_pop_ok)
      w_count_next = r_count + (ADDR_W+1)'(1);
    else if (!w_push_ok && w_pop_ok)
      w_count_next = r_count - (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_rd_valid     <= 1'b0;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_push_ok)
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop_ok)
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      r_count        <= w_count_next;
      r_full         <= (w_count_next == (ADDR_W+1)'(DEPTH));
      r_empty        <= (w_count_next == '0);
      r_almost_full  <= (w_count_next >= (ADDR_W+1)'(AF_THRESH));
      r_almost_empty <= (w_count_next <= (ADDR_W+1)'(AE_THRESH));
      r_rd_valid     <= w_pop_ok;
      // A new error event outranks a same-cycle clear.
      r_overflow     <= (bus.push & r_full)  | (r_overflow  & ~bus.clear_errors);
      r_underflow    <= (bus.pop  & r_empty) | (r_underflow & ~bus.clear_errors);
    end
  end

  assign bus.mem_write_enable  = w_push_ok;
  assign bus.mem_write_address = r_wr_ptr;
  assign bus.mem_write_data    = bus.wr_data;
  assign bus.mem_read_enable   = w_pop_ok;
  assign bus.mem_read_address  = r_rd_ptr;
  assign bus.rd_valid          = r_rd_valid;
  assign bus.full              = r_full;
  assign bus.empty             = r_empty;
  assign bus.almost_full       = r_almost_full;
  assign bus.almost_empty      = r_almost_empty;
  assign bus.count             = r_count;
  assign bus.overflow          = r_overflow;
  assign bus.underflow         = r_underflow;
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - directed self-checking bench for fifo_ctrl with a behavioural RAM
module tb_fifo_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fifo_ctrl_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  fifo_ctrl #(.DATA_W(8), .ADDR_W(3), .AF_THRESH(6), .AE_THRESH(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  logic [7:0] ram [0:7];
  logic [7:0] ram_rdata;

  always @(posedge clk) begin
    if (bus.mem_write_enable) ram[bus.mem_write_address] <= bus.mem_write_data;
    if (bus.mem_read_enable)  ram_rdata <= ram[bus.mem_read_address];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic q, input logic [7:0] d, input logic c);
    bus.push = p; bus.pop = q; bus.wr_data = d; bus.clear_errors = c;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
    checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae: got %b expected 1", bus.almost_empty); end
    checks++; if (bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin errors++; $display("FAIL reset_full_af: got %b%b expected 00", bus.full, bus.almost_full); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); end
    checks++; if (bus.mem_write_enable !== 1'b0 || bus.mem_read_enable !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b%b expected 00", bus.mem_write_enable, bus.mem_read_enable); end
    checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin errors++; $display("FAIL reset_errs: got %b%b expected 00", bus.overflow, bus.underflow); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 8'(16 + i), 1'b0);
      checks++; if (bus.mem_write_enable !== 1'b1 || bus.mem_write_address !== 3'(i)) begin errors++; $display("FAIL fill_waddr[%0d]: got we=%b a=%0d expected we=1 a=%0d", i, bus.mem_write_enable, bus.mem_write_address, i); end
      checks++; if (bus.mem_write_data !== 8'(16 + i)) begin errors++; $display("FAIL fill_wdata[%0d]: got %h expected %h", i, bus.mem_write_data, 8'(16 + i)); end
      tick();
      checks++; if (bus.count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, bus.count, i + 1); end
      checks++; if (bus.almost_full !== ((i + 1) >= 6)) begin errors++; $display("FAIL fill_af[%0d]: got %b expected %b", i, bus.almost_full, ((i + 1) >= 6)); end
      checks++; if (bus.full !== (i == 7)) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, bus.full, (i == 7)); end
    end
    drive(1'b1, 1'b0, 8'hEE, 1'b0);
    checks++; if (bus.mem_write_enable !== 1'b0) begin errors++; $display("FAIL ovf_we: got %b expected 0", bus.mem_write_enable); end
    tick();
    checks++; if (bus.overflow !== 1'b1 || bus.count !== 4'd8) begin errors++; $display("FAIL ovf_set: got ovf=%b cnt=%0d expected ovf=1 cnt=8", bus.overflow, bus.count); end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", bus.overflow); end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", bus.overflow); end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      checks++; if (bus.mem_read_enable !== 1'b1 || bus.mem_read_address !== 3'(i)) begin errors++; $display("FAIL drain_raddr[%0d]: got re=%b a=%0d expected re=1 a=%0d", i, bus.mem_read_enable, bus.mem_read_address, i); end
      tick();
      checks++; if (bus.rd_valid !== 1'b1 || ram_rdata !== 8'(16 + i)) begin errors++; $display("FAIL drain_data[%0d]: got v=%b d=%h expected v=1 d=%h", i, bus.rd_valid, ram_rdata, 8'(16 + i)); end
      checks++; if (bus.count !== 4'(7 - i) || bus.empty !== (i == 7) || bus.almost_empty !== ((7 - i) <= 2)) begin errors++; $display("FAIL drain_flags[%0d]: got cnt=%0d e=%b ae=%b expected cnt=%0d e=%b ae=%b", i, bus.count, bus.empty, bus.almost_empty, 7 - i, (i == 7), ((7 - i) <= 2)); end
    end
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if (bus.mem_read_enable !== 1'b0) begin errors++; $display("FAIL udf_re: got %b expected 0", bus.mem_read_enable); end
    tick();
    checks++; if (bus.underflow !== 1'b1 || bus.rd_valid !== 1'b0) begin errors++; $display("FAIL udf_set: got udf=%b v=%b expected udf=1 v=0", bus.underflow, bus.rd_valid); end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL udf_clear: got %b expected 0", bus.underflow); end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_wrap();
    logic [2:0] exp_addr [0:5];
    exp_addr[0] = 3'd5; exp_addr[1] = 3'd6; exp_addr[2] = 3'd7;
    exp_addr[3] = 3'd0; exp_addr[4] = 3'd1; exp_addr[5] = 3'd2;
    for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b0, 8'(i), 1'b0); tick(); end
    for (int i = 0; i < 5; i++) begin drive(1'b0, 1'b1, 8'h00, 1'b0); tick(); end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 8'(160 + i), 1'b0);
      checks++; if (bus.mem_write_address !== exp_addr[i]) begin errors++; $display("FAIL wrap_waddr[%0d]: got %0d expected %0d", i, bus.mem_write_address, exp_addr[i]); end
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (bus.count !== 4'd6) begin errors++; $display("FAIL wrap_count: got %0d expected 6", bus.count); end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      checks++; if (bus.mem_read_address !== exp_addr[i]) begin errors++; $display("FAIL wrap_raddr[%0d]: got %0d expected %0d", i, bus.mem_read_address, exp_addr[i]); end
      tick();
      checks++; if (bus.rd_valid !== 1'b1 || ram_rdata !== 8'(160 + i)) begin errors++; $display("FAIL wrap_data[%0d]: got v=%b d=%h expected v=1 d=%h", i, bus.rd_valid, ram_rdata, 8'(160 + i)); end
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_simultaneous();
    // pointers are both 3 here, count 0
    for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b0, 8'(48 + i), 1'b0); tick(); end
    drive(1'b1, 1'b1, 8'h77, 1'b0);
    checks++; if (bus.mem_write_enable !== 1'b1 || bus.mem_read_enable !== 1'b1 || bus.mem_write_address !== 3'd7 || bus.mem_read_address !== 3'd3) begin errors++; $display("FAIL mid_both: got we=%b re=%b wa=%0d ra=%0d expected 1 1 7 3", bus.mem_write_enable, bus.mem_read_enable, bus.mem_write_address, bus.mem_read_address); end
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (bus.count !== 4'd4 || bus.rd_valid !== 1'b1 || ram_rdata !== 8'h30) begin errors++; $display("FAIL mid_result: got cnt=%0d v=%b d=%h expected cnt=4 v=1 d=30", bus.count, bus.rd_valid, ram_rdata); end
    checks++; if (bus.mem_write_address !== 3'd0 || bus.mem_read_address !== 3'd4) begin errors++; $display("FAIL mid_ptrs: got wa=%0d ra=%0d expected 0 4", bus.mem_write_address, bus.mem_read_address); end
    for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b0, 8'(64 + i), 1'b0); tick(); end
    drive(1'b1, 1'b1, 8'hEE, 1'b0);
    checks++; if (bus.mem_write_enable !== 1'b0 || bus.mem_read_enable !== 1'b1) begin errors++; $display("FAIL full_both_en: got we=%b re=%b expected 0 1", bus.mem_write_enable, bus.mem_read_enable); end
    tick();
    checks++; if (bus.count !== 4'd7 || bus.overflow !== 1'b1 || bus.full !== 1'b0 || bus.rd_valid !== 1'b1) begin errors++; $display("FAIL full_both: got cnt=%0d ovf=%b f=%b v=%b expected 7 1 0 1", bus.count, bus.overflow, bus.full, bus.rd_valid); end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    for (int i = 0; i < 7; i++) begin drive(1'b0, 1'b1, 8'h00, 1'b0); tick(); end
    drive(1'b1, 1'b1, 8'h55, 1'b0);
    checks++; if (bus.mem_write_enable !== 1'b1 || bus.mem_read_enable !== 1'b0) begin errors++; $display("FAIL empty_both_en: got we=%b re=%b expected 1 0", bus.mem_write_enable, bus.mem_read_enable); end
    tick();
    checks++; if (bus.count !== 4'd1 || bus.underflow !== 1'b1 || bus.rd_valid !== 1'b0 || bus.empty !== 1'b0) begin errors++; $display("FAIL empty_both: got cnt=%0d udf=%b v=%b e=%b expected 1 1 0 0", bus.count, bus.underflow, bus.rd_valid, bus.empty); end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (bus.rd_valid !== 1'b1 || ram_rdata !== 8'h55) begin errors++; $display("FAIL pre_rst_read: got v=%b d=%h expected v=1 d=55", bus.rd_valid, ram_rdata); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.rd_valid !== 1'b0 || bus.count !== 4'd0 || bus.empty !== 1'b1) begin errors++; $display("FAIL async_rst: got v=%b cnt=%0d e=%b expected 0 0 1", bus.rd_valid, bus.count, bus.empty); end
    checks++; if (bus.mem_write_address !== 3'd0 || bus.mem_read_address !== 3'd0 || bus.underflow !== 1'b0) begin errors++; $display("FAIL async_rst_ptrs: got wa=%0d ra=%0d udf=%b expected 0 0 0", bus.mem_write_address, bus.mem_read_address, bus.underflow); end
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, 8'h99, 1'b0);
    checks++; if (bus.mem_write_enable !== 1'b1 || bus.mem_write_address !== 3'd0) begin errors++; $display("FAIL post_rst_push: got we=%b a=%0d expected 1 0", bus.mem_write_enable, bus.mem_write_address); end
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL post_rst_count: got %0d expected 1", bus.count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.wr_data = 8'h00; bus.clear_errors = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer and flag controller for the 8-entry x 8-bit synchronous FIFO.
- Sits directly upstream of the two-port FIFO RAM. Drives the RAM's write_enable, write_address, write_data, read_enable and read_address.
- Accepts push/pop requests from producer and consumer, and guards against overflow and underflow.
- Produces full/empty/almost flags, an occupancy count, and a read-valid strobe aligned with the RAM's registered read_data.

Parameters:
- DATA_W, 8, data width; must match RAM word width.
- ADDR_W, 3, address width; depth = 2**ADDR_W = 8.
- AF_THRESH, 6, almost_full asserted when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- push  input  1  producer write request.
- wr_data  input  DATA_W  producer data.
- pop  input  1  consumer read request.
- clear_errors  input  1  clears sticky overflow/underflow.
- mem_write_enable  output  1  to RAM write_enable.
- mem_write_address  output  ADDR_W  to RAM write_address (= wr_ptr).
- mem_write_data  output  DATA_W  to RAM write_data (= wr_data passthrough).
- mem_read_enable  output  1  to RAM read_enable.
- mem_read_address  output  ADDR_W  to RAM read_address (= rd_ptr).
- rd_valid  output  1  RAM read_data valid this cycle.
- full, empty, almost_full, almost_empty  output  1 each  registered status flags.
- count  output  ADDR_W+1  occupancy 0..8.
- overflow, underflow  output  1 each  sticky error flags.

Behaviour:
- Reset (async, rst=1) takes effect immediately, no clock needed:
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, almost_empty=1, full=0, almost_full=0.
  - rd_valid=0, overflow=0, underflow=0.
  - RAM contents are not cleared.
- Acceptance is combinational from current registered state:
  - push_ok = push & !full.
  - pop_ok = pop & !empty.
  - mem_write_enable = push_ok; mem_read_enable = pop_ok.
  - Addresses are the current pointers.
- Pointer update on the clock edge:
  - push_ok: wr_ptr+1, wrapping 7->0 naturally in ADDR_W bits.
  - pop_ok: rd_ptr+1, same wrap.
- count update on the clock edge:
  - +1 on push_ok only; -1 on pop_ok only; unchanged when both or neither.
- Read latency: RAM registers read_data on the edge where pop_ok=1. rd_valid is pop_ok registered, so it is high the cycle after acceptance, exactly when read_data is valid.
- Flags are registered from the next count value (no extra cycle of lag):
  - full = (count_next == 8); empty = (count_next == 0).
  - almost_full = (count_next >= AF_THRESH).
  - almost_empty = (count_next <= AE_THRESH).
- Simultaneous push and pop:
  - Mid-occupancy: both accepted, count unchanged. The RAM handles different addresses in the same cycle.
  - When full: pop accepted, push rejected, overflow set. Count becomes 7.
  - When empty: push accepted, pop rejected, underflow set, no read-through. Count becomes 1; rd_valid stays 0 next cycle.
- Errors:
  - overflow set on any clock edge with push & full; underflow set on any edge with pop & empty.
  - Both are sticky until clear_errors. If set and clear occur in the same cycle, set wins.
- Reset mid-operation: a pending rd_valid drops immediately; the read in flight is discarded. After reset release, the first push writes address 0.
- No combinational path from push/pop to any status flag or count.

Test Plan:
- Reset then idle -> empty=1, almost_empty=1, count=0, rd_valid=0, all mem enables 0.
- Push 8 words 0x10..0x17 on consecutive cycles:
  - mem_write_address steps 0..7.
  - almost_full rises after the 6th push; full=1 and count=8 after the 8th.
  - A 9th push gives mem_write_enable=0 and overflow=1 (sticky); clear_errors then clears it.
- Pop 8 from full:
  - mem_read_address steps 0..7; rd_valid is high one cycle after each pop; data read equals 0x10..0x17.
  - empty=1 after the 8th pop; a further pop sets underflow=1 with no rd_valid.
- Wrap-around:
  - Push 5, pop 5, push 6 -> mem_write_address sequence 5,6,7,0,1,2; count=6.
  - Data pops out in order across the wrap.
- Simultaneous push+pop:
  - At count=4: count stays 4, both pointers advance.
  - At full: count=7, overflow=1.
  - At empty: count=1, underflow=1, rd_valid=0.
- Assert rst asynchronously mid-cycle while rd_valid=1 -> rd_valid, count and pointers drop to 0 before the next clk edge; empty=1.
